uart_rx: RTL and testbench

//  Serial UART receiver. Oversamples the rx line with the 16x s_tick strobe from the baud generator.

---
 rtl/uart_rx_if.sv | 37 +++
 rtl/uart_rx.sv | 164 ++++++++++++++++
 tb/tb_uart_rx.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_if
// Purpose  : Serial input and byte-output bundle for uart_rx.
// Optional : parity_err exists only when UART_RX_PARITY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_rx_if #(
  parameter int DBIT = 8
);
  logic            s_tick;
  logic            rx;
  logic [DBIT-1:0] dout;
  logic            rx_done_tick;
  logic            frame_err;
  logic            busy;
`ifdef UART_RX_PARITY_EN
  logic            parity_err;
`endif

  modport slave (
    input  s_tick, rx,
    output dout, rx_done_tick, frame_err, busy
`ifdef UART_RX_PARITY_EN
    , parity_err
`endif
  );

  modport master (
    output s_tick, rx,
    input  dout, rx_done_tick, frame_err, busy
`ifdef UART_RX_PARITY_EN
    , parity_err
`endif
  );
endinterface
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Purpose  : 16x-oversampling UART receiver, LSB first, one done pulse per frame.
// Optional : UART_RX_PARITY_EN adds a parity bit, parameter ODD and parity_err.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
`ifdef UART_RX_PARITY_EN
  , parameter bit ODD   = 1'b0
`endif
) (
  input  wire logic  clk,
  input  wire logic  rst_n,
  uart_rx_if.slave   bus
);

  localparam int             c_NW      = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam logic [c_NW-1:0] c_N_LAST = c_NW'(DBIT - 1);
  localparam logic [c_NW-1:0] c_N_ONE  = c_NW'(1);
  localparam logic [4:0]     c_SB_LAST = 5'(SB_TICK - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3
`ifdef UART_RX_PARITY_EN
    , S_PARITY = 3'd4
`endif
  } state_t;

`ifdef UART_RX_PARITY_EN
  localparam state_t c_AFTER_DATA = S_PARITY;
`else
  localparam state_t c_AFTER_DATA = S_STOP;
`endif

  state_t          r_state;
  logic [4:0]      r_s;
  logic [c_NW-1:0] r_n;
  logic [DBIT-1:0] r_sh;
  logic [DBIT-1:0] r_dout;
  logic            r_done;
  logic            r_frame_err;
  logic            r_sync1;
  logic            r_sync2;
  logic            w_rx_s;
`ifdef UART_RX_PARITY_EN
  logic            r_p;
  logic            r_parity_err;
`endif

  // rx is asynchronous to clk; flops preset high so reset looks like an idle line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= bus.rx;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rx_s = r_sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_s         <= '0;
      r_n         <= '0;
      r_sh        <= '0;
      r_dout      <= '0;
      r_done      <= 1'b0;
      r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_p          <= 1'b0;
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!w_rx_s) begin
            r_state <= S_START;
            r_s     <= '0;
          end
        end
        S_START: begin
          if (bus.s_tick) begin
            if (r_s == 5'd7) begin
              // Line must still be low at the start-bit midpoint, else it was a glitch.
              if (!w_rx_s) begin
                r_state <= S_DATA;
                r_s     <= '0;
                r_n     <= '0;
              end else begin
                r_state <= S_IDLE;
              end
            end else begin
              r_s <= r_s + 5'd1;
            end
          end
        end
        S_DATA: begin
          if (bus.s_tick) begin
            if (r_s == 5'd15) begin
              r_sh <= {w_rx_s, r_sh[DBIT-1:1]};
              r_s  <= '0;
              if (r_n == c_N_LAST) begin
                r_state <= c_AFTER_DATA;
              end else begin
                r_n <= r_n + c_N_ONE;
              end
            end else begin
              r_s <= r_s + 5'd1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (bus.s_tick) begin
            if (r_s == 5'd15) begin
              r_p     <= w_rx_s;
              r_s     <= '0;
              r_state <= S_STOP;
            end else begin
              r_s <= r_s + 5'd1;
            end
          end
        end
`endif
        S_STOP: begin
          if (bus.s_tick) begin
            if (r_s == c_SB_LAST) begin
              r_state     <= S_IDLE;
              r_dout      <= r_sh;
              r_frame_err <= ~w_rx_s;
              r_done      <= 1'b1;
`ifdef UART_RX_PARITY_EN
              r_parity_err <= (^r_sh) ^ r_p ^ ODD;
`endif
            end else begin
              r_s <= r_s + 5'd1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.dout         = r_dout;
  assign bus.rx_done_tick = r_done;
  assign bus.frame_err    = r_frame_err;
  assign bus.busy         = (r_state != S_IDLE);
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err   = r_parity_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Purpose  : Directed frames against a queue-based frame model of uart_rx.
// Optional : UART_RX_PARITY_EN enables the parity scenarios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

  localparam int c_BIT_CLK  = 64;
  localparam int c_SB_TICK  = 16;
  localparam int c_MAX_LAT  = 640 + c_SB_TICK * 4;
  localparam bit c_ODD      = 1'b0;

  typedef struct {
    logic [7:0] data;
    logic       fe;
    logic       pe;
    int         t0;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_tests;
  int   n_fail;
  int   n_done;
  exp_t exp_q[$];

  logic [7:0] mdl_dout;
  logic       mdl_fe;
  logic       mdl_pe;

  uart_rx_if #(.DBIT(8)) bus ();

  uart_rx #(.DBIT(8), .SB_TICK(c_SB_TICK)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // 16x baud strobe: one clk high every 4 clk.
  initial begin
    int div;
    div = 0;
    bus.s_tick = 1'b0;
    forever begin
      @(negedge clk);
      div = (div + 1) % 4;
      bus.s_tick = (div == 0);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Frame model: a completed frame yields its data, error iff stop sampled low,
  // parity error iff total ones (data + parity bit) disagrees with ODD.
  task automatic send_frame(input logic [7:0] d, input bit stop, input bit par, input int gap);
    exp_t e;
    e.data = d;
    e.fe   = ~stop;
    e.pe   = ((($countones(d) + int'(par)) % 2) != int'(c_ODD));
    e.t0   = cyc;
    exp_q.push_back(e);
    bus.rx = 1'b0;
    wait_clk(c_BIT_CLK);
    for (int i = 0; i < 8; i++) begin
      bus.rx = d[i];
      wait_clk(c_BIT_CLK);
    end
`ifdef UART_RX_PARITY_EN
    bus.rx = par;
    wait_clk(c_BIT_CLK);
`endif
    bus.rx = stop;
    wait_clk(40);
    bus.rx = 1'b1;
    wait_clk(24 + gap);
  endtask

  // Compare process: every done is matched to the oldest sent frame; outputs hold otherwise.
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      mdl_dout = 8'h00;
      mdl_fe   = 1'b0;
      mdl_pe   = 1'b0;
    end else begin
      if (bus.rx_done_tick) begin
        n_done++;
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          mdl_dout = e.data;
          mdl_fe   = e.fe;
          mdl_pe   = e.pe;
          check("done_latency_ok", 32'(cyc - e.t0 <= c_MAX_LAT), 32'd1);
        end
      end
      check("dout", 32'(bus.dout), 32'(mdl_dout));
      check("frame_err", 32'(bus.frame_err), 32'(mdl_fe));
`ifdef UART_RX_PARITY_EN
      check("parity_err", 32'(bus.parity_err), 32'(mdl_pe));
`endif
    end
  end

  initial begin
    int  done0;
    bit  saw_busy;
    cyc      = 0;
    n_tests  = 0;
    n_fail   = 0;
    n_done   = 0;
    mdl_dout = 8'h00;
    mdl_fe   = 1'b0;
    mdl_pe   = 1'b0;
    bus.rx   = 1'b1;
    rst_n    = 1'b0;

    // 1. reset state and quiet idle line
    wait_clk(5);
    check("rst_dout", 32'(bus.dout), 32'h0);
    check("rst_done", 32'(bus.rx_done_tick), 32'h0);
    check("rst_frame_err", 32'(bus.frame_err), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    rst_n = 1'b1;
    wait_clk(2000);
    check("idle_no_done", 32'(n_done), 32'd0);

    // 2. good 0x55
    send_frame(8'h55, 1'b1, 1'b0, 100);
    check("b55_dout", 32'(bus.dout), 32'h55);
    check("b55_fe", 32'(bus.frame_err), 32'h0);
    check("b55_count", 32'(n_done), 32'd1);

    // 3. short low glitch: busy rises, no byte
    done0    = n_done;
    saw_busy = 1'b0;
    bus.rx   = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      saw_busy |= bus.busy;
    end
    bus.rx = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      saw_busy |= bus.busy;
    end
    check("glitch_busy_seen", 32'(saw_busy), 32'd1);
    check("glitch_busy_clear", 32'(bus.busy), 32'd0);
    check("glitch_no_done", 32'(n_done - done0), 32'd0);
    check("glitch_dout_kept", 32'(bus.dout), 32'h55);

    // 4. bad stop bit, then recovery
    send_frame(8'hA3, 1'b0, 1'b0, 200);
    check("bA3_dout", 32'(bus.dout), 32'hA3);
    check("bA3_fe", 32'(bus.frame_err), 32'h1);
    send_frame(8'h0F, 1'b1, 1'b0, 100);
    check("b0F_dout", 32'(bus.dout), 32'h0F);
    check("b0F_fe", 32'(bus.frame_err), 32'h0);

    // 5. reset mid-frame after bit 4 of 0xFF
    done0  = n_done;
    bus.rx = 1'b0;
    wait_clk(c_BIT_CLK);
    bus.rx = 1'b1;
    wait_clk(5 * c_BIT_CLK);
    rst_n = 1'b0;
    wait_clk(1);
    check("midrst_dout", 32'(bus.dout), 32'h0);
    check("midrst_busy", 32'(bus.busy), 32'h0);
    wait_clk(10);
    rst_n = 1'b1;
    wait_clk(100);
    send_frame(8'h3C, 1'b1, 1'b0, 100);
    check("b3C_dout", 32'(bus.dout), 32'h3C);
    check("b3C_one_done", 32'(n_done - done0), 32'd1);

    // 6. back-to-back frames with no idle gap
    done0 = n_done;
    send_frame(8'h01, 1'b1, 1'b1, 0);
    send_frame(8'h80, 1'b1, 1'b1, 100);
    check("b2b_two_done", 32'(n_done - done0), 32'd2);
    check("b2b_last", 32'(bus.dout), 32'h80);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1, 100);
    check("par07_p1", 32'(bus.parity_err), 32'h0);
    send_frame(8'h07, 1'b1, 1'b0, 100);
    check("par07_p0", 32'(bus.parity_err), 32'h1);
`endif

    wait_clk(200);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
